aes_spi_host_seq: RTL and testbench
===================================

Name: aes_spi_host_seq

Overview:
Host-side transaction sequencer that sits directly upstream of SPI_Main and drives the AES_Encrypt SPI slave through a full encryption. On one request it issues three SPI frames in order: key, plaintext, then an all-zero readback. It captures the ciphertext returned on the readback frame and presents it with a valid strobe. It replaces hand-timed start pulses with a done-driven handshake, a fixed inter-frame gap, and a timeout.

Parameters:
GAP_CYCLES, 4, idle clk cycles between a frame's spi_done and the next spi_start (range 1..255)
TIMEOUT_CYCLES, 4096, max clk cycles from spi_start to spi_done before abort (16-bit counter)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  1  start an encryption; accepted only when busy=0
key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
key  input  256  key, MSB-aligned; AES-128 uses [255:128], AES-192 uses [255:64]
pt  input  128  plaintext block
busy  output  1  high from req acceptance until ct_valid or err
ct  output  128  captured ciphertext
ct_valid  output  1  one-cycle pulse when ct updates
err  output  1  one-cycle pulse on timeout or illegal key_len
spi_start  output  1  one-cycle start pulse to SPI_Main
spi_tx  output  258  frame to SPI_Main; [257:256]=key-length tag, [255:0]=payload MSB-aligned
spi_rx  input  128  word received by SPI_Main on the last frame
spi_done  input  1  one-cycle pulse from SPI_Main at frame end

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, ct_valid, err, spi_start all 0; ct=0; spi_tx=0; counters=0. Reset asserted mid-sequence aborts immediately. No SPI start is issued after reset until a new req arrives.
- States: IDLE, KEY_TX, KEY_WAIT, GAP1, MSG_TX, MSG_WAIT, GAP2, RD_TX, RD_WAIT, DONE.
- IDLE, req=1, legal key_len: latch key, key_len and pt into internal registers, set busy, go to KEY_TX. Later changes to the inputs are ignored.
- IDLE, req=1, key_len=11: pulse err for one cycle, busy stays 0, remain in IDLE.
- KEY_TX: spi_tx={key_len, key}. Payload bits below the key size are driven 0. Assert spi_start for 1 cycle, then go to KEY_WAIT. The first spi_start occurs 1 cycle after req is sampled.
- MSG_TX: spi_tx={2'b00, pt, 128'h0}.
- RD_TX: spi_tx=258'h0.
- spi_tx holds its value from the *_TX cycle until the next *_TX state.
- *_WAIT: wait for spi_done. KEY_WAIT then goes to GAP1, MSG_WAIT to GAP2, RD_WAIT to DONE. A spi_done arriving in any other state is ignored.
- GAPn: count GAP_CYCLES cycles, then go to the next *_TX.
- RD_WAIT with spi_done=1: ct<=spi_rx in that same cycle, then go to DONE.
- DONE: ct_valid=1 and busy=0 for one cycle, then IDLE. A req sampled in DONE is ignored; req must be reasserted in IDLE.
- Timeout: the counter clears on every spi_start and increments each cycle in *_WAIT. When it reaches TIMEOUT_CYCLES-1 with no spi_done: err pulses, busy drops, state goes to IDLE, and ct is unchanged. If spi_done arrives in the same cycle as the terminal count, spi_done wins.
- ct holds its last value until the next successful readback.

Optional Feature:
AES_SEQ_KEY_CACHE_EN
- Defined: keep a copy of the last key and key_len that completed KEY_WAIT successfully. If an accepted req matches both, skip KEY_TX, KEY_WAIT and GAP1 and go straight to MSG_TX. The first spi_start then carries the plaintext frame.
- The cache is invalidated by reset and by any err.
- Not defined: the key frame is sent on every req. No cache registers exist.

Test Plan:
- AES-128: key=000102030405060708090a0b0c0d0e0f, key_len=00, pt=00112233445566778899aabbccddeeff, with SPI_Main and AES_Encrypt attached -> exactly 3 spi_start pulses, ct_valid once, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192: key=000102…1617, key_len=01 -> key frame spi_tx[257:256]=01 and spi_tx[63:0]=0; ct=dda97ca4864cdfe06eaf70a0ec0d7191.
- AES-256: key=000102…1e1f, key_len=10 -> ct=8ea2b7ca516745bfeafc49904b496089. Check spacing between each spi_done and the next spi_start is GAP_CYCLES+1 cycles.
- Stub SPI that never pulses spi_done, TIMEOUT_CYCLES=64 -> err pulses 64 cycles after the first spi_start, busy=0, ct unchanged. Then key_len=11 -> err with no spi_start.
- rst_n=0 during MSG_WAIT -> next cycle busy=0 and no further spi_start. A later req runs a full 3-frame sequence. With AES_SEQ_KEY_CACHE_EN: a repeated identical AES-128 req -> only 2 spi_start pulses and the same ct.

Source files
------------

// File: rtl/aes_spi_host_seq.sv
// Host sequencer driving an AES SPI slave: key frame, plaintext frame, zero readback frame.
// Optional key cache guarded by `AES_SEQ_KEY_CACHE_EN` skips the key frame for a repeated key.
module aes_spi_host_seq #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    input  logic [127:0] pt,
    output logic         busy,
    output logic [127:0] ct,
    output logic         ct_valid,
    output logic         err,
    output logic         spi_start,
    output logic [257:0] spi_tx,
    input  logic [127:0] spi_rx,
    input  logic         spi_done
);

    typedef enum logic [3:0] {
        IDLE, KEY_TX, KEY_WAIT, GAP1, MSG_TX, MSG_WAIT, GAP2, RD_TX, RD_WAIT, DONE
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t         r_state;
    logic [7:0]     r_gap;
    logic [15:0]    r_cnt;
    logic [1:0]     r_len;
    logic [255:0]   r_key;
    logic [127:0]   r_pt;
    logic [255:0]   w_key_masked;
    logic           w_cache_hit;

    // NOTE: default assignment first so every path drives w_key_masked and no latch is inferred.
    always_comb begin
        w_key_masked = key;
        case (key_len)
            2'b00:   w_key_masked[127:0] = '0;
            2'b01:   w_key_masked[63:0]  = '0;
            default: ;
        endcase
    end

`ifdef AES_SEQ_KEY_CACHE_EN
    logic           r_cache_vld;
    logic [1:0]     r_cache_len;
    logic [255:0]   r_cache_key;

    assign w_cache_hit = r_cache_vld && (r_cache_len == key_len) && (r_cache_key == w_key_masked);
`else
    assign w_cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gap     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_key     <= '0;
            r_pt      <= '0;
            busy      <= 1'b0;
            ct        <= '0;
            ct_valid  <= 1'b0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            spi_tx    <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
            r_cache_vld <= 1'b0;
            r_cache_len <= '0;
            r_cache_key <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout; pulse outputs default low and are raised for one cycle below.
            spi_start <= 1'b0;
            err       <= 1'b0;
            ct_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (key_len == 2'b11) begin
                            err <= 1'b1;
`ifdef AES_SEQ_KEY_CACHE_EN
                            r_cache_vld <= 1'b0;
`endif
                        end else begin
                            r_len     <= key_len;
                            r_key     <= w_key_masked;
                            r_pt      <= pt;
                            busy      <= 1'b1;
                            spi_start <= 1'b1;
                            r_cnt     <= '0;
                            if (w_cache_hit) begin
                                spi_tx  <= {2'b00, pt, 128'h0};
                                r_state <= MSG_TX;
                            end else begin
                                spi_tx  <= {key_len, w_key_masked};
                                r_state <= KEY_TX;
                            end
                        end
                    end
                end
                KEY_TX: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= KEY_WAIT;
                end
                MSG_TX: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= MSG_WAIT;
                end
                RD_TX: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= RD_WAIT;
                end
                KEY_WAIT, MSG_WAIT, RD_WAIT: begin
                    // spi_done takes priority over the terminal timeout count
                    if (spi_done) begin
                        r_gap <= '0;
                        case (r_state)
                            KEY_WAIT: begin
                                r_state <= GAP1;
`ifdef AES_SEQ_KEY_CACHE_EN
                                r_cache_vld <= 1'b1;
                                r_cache_len <= r_len;
                                r_cache_key <= r_key;
`endif
                            end
                            MSG_WAIT: r_state <= GAP2;
                            default: begin
                                ct       <= spi_rx;
                                ct_valid <= 1'b1;
                                busy     <= 1'b0;
                                r_state  <= DONE;
                            end
                        endcase
                    end else if (r_cnt >= TO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
`ifdef AES_SEQ_KEY_CACHE_EN
                        r_cache_vld <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                GAP1: begin
                    if (r_gap >= GAP_LAST) begin
                        spi_tx    <= {2'b00, r_pt, 128'h0};
                        spi_start <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= MSG_TX;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                GAP2: begin
                    if (r_gap >= GAP_LAST) begin
                        spi_tx    <= '0;
                        spi_start <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RD_TX;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_host_seq.sv
// Self-checking bench for aes_spi_host_seq: behavioural SPI/AES stub plus a frame-level reference model.
// Build with AES_SEQ_KEY_CACHE_EN defined to exercise the key cache expectations.
module tb_aes_spi_host_seq;

    localparam int GAP = 4;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [127:0] pt;
    logic         busy;
    logic [127:0] ct;
    logic         ct_valid;
    logic         err;
    logic         spi_start;
    logic [257:0] spi_tx;
    logic [127:0] spi_rx   = '0;
    logic         spi_done = 1'b0;

    always #5 clk = ~clk;

    aes_spi_host_seq #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .key_len(key_len), .key(key), .pt(pt),
        .busy(busy), .ct(ct), .ct_valid(ct_valid), .err(err),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_done(spi_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub knobs, written only by the stimulus tasks
    int           lat_min   = 1;
    int           lat_max   = 8;
    bit           stub_dead = 1'b0;
    logic [127:0] rx_value  = '0;

    // Observations, written only by the monitor
    int           n_start = 0;
    int           n_done  = 0;
    int           n_err   = 0;
    int           n_ctv   = 0;
    int           err_cyc = 0;
    int           start_cyc[$];
    int           done_cyc[$];
    logic [257:0] frames[$];

    // SPI_Main + AES slave stand-in: answers each frame after a random latency,
    // returning the ciphertext only on the all-zero readback frame.
    int           stub_cnt  = -1;
    logic [257:0] cur_frame = '0;
    always @(negedge clk) begin
        spi_done = 1'b0;
        if (err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if (ct_valid === 1'b1) n_ctv++;
        if (rst_n !== 1'b1) begin
            stub_cnt = -1;
        end else if (spi_start === 1'b1) begin
            n_start++;
            frames.push_back(spi_tx);
            start_cyc.push_back(cyc);
            cur_frame = spi_tx;
            stub_cnt  = stub_dead ? -1 : int'($urandom_range(lat_max, lat_min));
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                spi_done = 1'b1;
                n_done++;
                done_cyc.push_back(cyc);
                spi_rx   = (cur_frame == '0) ? rx_value : {$urandom, $urandom, $urandom, $urandom};
                stub_cnt = -1;
            end
        end
    end

    // Reference model state
    bit           m_cvld = 1'b0;
    logic [1:0]   m_clen = '0;
    logic [255:0] m_ckey = '0;
    logic [127:0] m_ct   = '0;

    function automatic logic [255:0] m_mask(input logic [1:0] len, input logic [255:0] k);
        int           bits;
        logic [255:0] m;
        bits = 128 + 64 * int'(len);
        m    = '1;
        m    = m << (256 - bits);
        return k & m;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue_req(input logic [1:0] len, input logic [255:0] k, input logic [127:0] p,
                             output int req_cyc);
        @(negedge clk);
        req = 1'b1; key_len = len; key = k; pt = p;
        req_cyc = cyc;
        @(negedge clk);
        req = 1'b0; key = ~k; pt = ~p; key_len = 2'($urandom_range(3, 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; key_len = '0; key = '0; pt = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, ct_valid, err, spi_start} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, ct_valid, err, spi_start});
        end
        checks++;
        if (ct !== '0) begin errors++; $display("FAIL reset_ct got=%h exp=0", ct); end
        checks++;
        if (spi_tx !== '0) begin errors++; $display("FAIL reset_spi_tx got=%h exp=0", spi_tx); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (n_start !== 0) begin errors++; $display("FAIL reset_no_start got=%0d exp=0", n_start); end
        m_cvld = 1'b0;
        m_ct   = '0;
    endtask

    task automatic run_txn(input string name, input logic [1:0] len, input logic [255:0] k,
                           input logic [127:0] p, input logic [127:0] rx, input int lmin, input int lmax);
        logic [257:0] exp_q[$];
        logic [255:0] mk;
        bit           hit;
        int           b_start, b_done, b_err, b_ctv, req_cyc, ns;
        mk = m_mask(len, k);
`ifdef AES_SEQ_KEY_CACHE_EN
        hit = m_cvld && (m_clen == len) && (m_ckey == mk);
`else
        hit = 1'b0;
`endif
        if (!hit) exp_q.push_back({len, mk});
        exp_q.push_back({2'b00, p, 128'h0});
        exp_q.push_back('0);
        rx_value = rx; lat_min = lmin; lat_max = lmax; stub_dead = 1'b0;
        b_start = n_start; b_done = n_done; b_err = n_err; b_ctv = n_ctv;
        issue_req(len, k, p, req_cyc);
        #1;
        checks++;
        if ({busy, spi_start} !== 2'b11) begin
            errors++;
            $display("FAIL %s accept busy,spi_start got=%b exp=11", name, {busy, spi_start});
        end
        for (int i = 0; i < 3000; i++) begin
            if (ct_valid === 1'b1 || err === 1'b1) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (ct_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s completion ct_valid=%b err=%b exp ct_valid=1", name, ct_valid, err);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s done_busy got=%b exp=0", name, busy); end
        checks++;
        if (ct !== rx) begin errors++; $display("FAIL %s ct got=%h exp=%h", name, ct, rx); end
        repeat (3) @(negedge clk);
        #1;
        ns = n_start - b_start;
        checks++;
        if (ns !== exp_q.size()) begin
            errors++;
            $display("FAIL %s start_count got=%0d exp=%0d", name, ns, exp_q.size());
        end
        checks++;
        if (n_ctv - b_ctv !== 1 || n_err - b_err !== 0) begin
            errors++;
            $display("FAIL %s pulses ct_valid=%0d err=%0d exp 1/0", name, n_ctv - b_ctv, n_err - b_err);
        end
        if (ns == exp_q.size()) begin
            for (int i = 0; i < ns; i++) begin
                checks++;
                if (frames[b_start + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s frame%0d got=%h exp=%h", name, i, frames[b_start + i], exp_q[i]);
                end
            end
            checks++;
            if (start_cyc[b_start] - req_cyc !== 1) begin
                errors++;
                $display("FAIL %s first_start_latency got=%0d exp=1", name, start_cyc[b_start] - req_cyc);
            end
            if (n_done - b_done >= ns) begin
                for (int i = 0; i < ns - 1; i++) begin
                    checks++;
                    if (start_cyc[b_start + i + 1] - done_cyc[b_done + i] !== GAP + 1) begin
                        errors++;
                        $display("FAIL %s gap%0d got=%0d exp=%0d", name, i,
                                 start_cyc[b_start + i + 1] - done_cyc[b_done + i], GAP + 1);
                    end
                end
            end
        end
        m_ct   = rx;
        m_cvld = 1'b1;
        m_clen = len;
        m_ckey = mk;
    endtask

    task automatic test_vectors();
        run_txn("aes128", 2'b00, {128'h000102030405060708090a0b0c0d0e0f, rand256() >> 128},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 12);
        // latency 63 lands spi_done on the terminal timeout count
        run_txn("aes192_slow", 2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hdeadbeefcafef00d},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 63, 63);
        run_txn("aes256", 2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 1, 20);
    endtask

    task automatic test_random();
        logic [255:0] pool[2];
        logic [127:0] p;
        pool[0] = rand256();
        pool[1] = rand256();
        for (int n = 0; n < 8; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            run_txn("random", 2'($urandom_range(2, 0)), pool[$urandom_range(1, 0)], p,
                    {$urandom, $urandom, $urandom, $urandom}, 1, 20);
        end
    endtask

    task automatic test_key_cache();
        logic [255:0] k;
        k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        run_txn("cache_first", 2'b00, k, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 10);
        run_txn("cache_repeat", 2'b00, k, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 10);
    endtask

    task automatic test_timeout();
        int b_start, b_err, b_ctv, req_cyc;
        stub_dead = 1'b1;
        b_start = n_start; b_err = n_err; b_ctv = n_ctv;
        issue_req(2'b10, rand256(), 128'h5, req_cyc);
        for (int i = 0; i < 300; i++) begin
            if (n_err != b_err) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n_err - b_err !== 1) begin
            errors++;
            $display("FAIL timeout_err got=%0d pulses exp=1", n_err - b_err);
        end else begin
            checks++;
            if (err_cyc - start_cyc[b_start] !== TMO) begin
                errors++;
                $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - start_cyc[b_start], TMO);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (ct !== m_ct) begin errors++; $display("FAIL timeout_ct got=%h exp=%h", ct, m_ct); end
        checks++;
        if (n_start - b_start !== 1 || n_ctv - b_ctv !== 0 || n_err - b_err !== 1) begin
            errors++;
            $display("FAIL timeout_quiet starts=%0d ct_valid=%0d err=%0d exp 1/0/1",
                     n_start - b_start, n_ctv - b_ctv, n_err - b_err);
        end
        stub_dead = 1'b0;
        m_cvld    = 1'b0;
    endtask

    task automatic test_illegal();
        int b_start, b_err, req_cyc;
        b_start = n_start; b_err = n_err;
        issue_req(2'b11, rand256(), 128'h9, req_cyc);
        #1;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_err_busy got=%b exp=10", {err, busy});
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (n_start - b_start !== 0 || n_err - b_err !== 1) begin
            errors++;
            $display("FAIL illegal_quiet starts=%0d err=%0d exp 0/1", n_start - b_start, n_err - b_err);
        end
        checks++;
        if (err_cyc - req_cyc !== 1) begin
            errors++;
            $display("FAIL illegal_err_cycle got=%0d exp=1", err_cyc - req_cyc);
        end
        m_cvld = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b_start, req_cyc;
        lat_min = 30; lat_max = 30; stub_dead = 1'b0; rx_value = 128'h1234;
        b_start = n_start;
        issue_req(2'b00, rand256(), 128'h77, req_cyc);
        for (int i = 0; i < 500; i++) begin
            if (n_start - b_start >= 2) break;
            @(negedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, spi_start} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_busy got=%b exp=00", {busy, spi_start});
        end
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        checks++;
        if (n_start - b_start !== 2) begin
            errors++;
            $display("FAIL reset_mid_starts got=%0d exp=2", n_start - b_start);
        end
        m_cvld = 1'b0;
        m_ct   = '0;
        run_txn("after_reset", 2'b00, rand256(), 128'h00112233445566778899aabbccddeeff,
                {$urandom, $urandom, $urandom, $urandom}, 1, 10);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_key_cache();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
